// File: rtl/mips_cpu_seq_pkg.sv
// Shared types and constants for the MIPS multi-cycle sequencer.
package mips_cpu_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    MULDIV = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;
  localparam logic PC_SEL_INC   = 1'b0;
  localparam logic PC_SEL_TGT   = 1'b1;

  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/mips_cpu_seq_lat_cnt.sv
// Loadable 6-bit down-counter that times the mult/div wait; saturates at zero.
module mips_cpu_seq_lat_cnt
  import mips_cpu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mips_cpu_seq_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/EXEC/MEM/MULDIV/HALTED with delay-slot tracking.
// Optional macro MIPS_SEQ_MULT_FAST_EN gives MULT/MULTU the shorter MULT_LAT latency.
module mips_cpu_seq_ctrl
  import mips_cpu_seq_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 32,
  parameter int unsigned MULT_LAT   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       waitrequest,
  input  logic       dec_load,
  input  logic       dec_store,
  input  logic       dec_muldiv,
  input  logic       dec_mult,
  input  logic       dec_regwrite,
  input  logic       branch_taken,
  input  logic       next_pc_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_en,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       regwrite_en,
  output logic       spc_we,
  output logic       muldiv_start,
  output logic       active,
  output logic [2:0] state_o
);

  seq_state_t       state_q, state_d;
  logic             pend_q, pend_d;
  logic             commit;
  logic             cnt_load;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_value;

`ifdef MIPS_SEQ_MULT_FAST_EN
  assign cnt_value = dec_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(MULDIV_LAT - 1);
`else
  logic unused_dec_mult;
  assign unused_dec_mult = dec_mult;
  assign cnt_value = CNT_W'(MULDIV_LAT - 1);
`endif

  mips_cpu_seq_lat_cnt u_lat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .value   (cnt_value),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    commit       = 1'b0;
    cnt_load     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_sel     = ADDR_SEL_PC;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEL_INC;
    regwrite_en  = 1'b0;
    spc_we       = 1'b0;
    muldiv_start = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (!waitrequest) begin
          ir_en   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_load || dec_store) begin
          state_d = MEM;
        end else if (dec_muldiv) begin
          muldiv_start = 1'b1;
          cnt_load     = 1'b1;
          state_d      = MULDIV;
        end else begin
          regwrite_en = dec_regwrite;
          commit      = 1'b1;
        end
      end
      MEM: begin
        addr_sel  = ADDR_SEL_ALU;
        mem_read  = dec_load;
        // Load wins if the decoder ever flags both, keeping read/write exclusive.
        mem_write = dec_store & ~dec_load;
        if (!waitrequest) begin
          regwrite_en = dec_load;
          commit      = 1'b1;
        end
      end
      MULDIV: begin
        if (cnt_zero) begin
          spc_we = 1'b1;
          commit = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase

    if (commit) begin
      pc_en   = 1'b1;
      pc_sel  = pend_q ? PC_SEL_TGT : PC_SEL_INC;
      state_d = next_pc_zero ? HALTED : FETCH;
      // A branch sitting in a delay slot never arms a new pending target.
      pend_d  = (state_q == EXEC) && branch_taken && !pend_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign active  = (state_q != HALTED);
  assign state_o = state_q;

endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// Scoreboard bench for mips_cpu_seq_ctrl: stimulus queues expected outputs per cycle.
module tb_mips_cpu_seq_ctrl;

  localparam logic [9:0] MR  = 10'h200;
  localparam logic [9:0] MW  = 10'h100;
  localparam logic [9:0] AS  = 10'h080;
  localparam logic [9:0] IR  = 10'h040;
  localparam logic [9:0] PE  = 10'h020;
  localparam logic [9:0] PS  = 10'h010;
  localparam logic [9:0] RW  = 10'h008;
  localparam logic [9:0] SPC = 10'h004;
  localparam logic [9:0] MS  = 10'h002;
  localparam logic [9:0] ACT = 10'h001;

`ifdef MIPS_SEQ_MULT_FAST_EN
  localparam int MULT_EXP = 4;
`else
  localparam int MULT_EXP = 32;
`endif

  typedef struct {
    logic [12:0] exp;
    string       name;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       waitrequest = 1'b1;
  logic       dec_load = 1'b0, dec_store = 1'b0, dec_muldiv = 1'b0, dec_mult = 1'b0;
  logic       dec_regwrite = 1'b0, branch_taken = 1'b0, next_pc_zero = 1'b0;
  logic       mem_read, mem_write, addr_sel, ir_en, pc_en, pc_sel;
  logic       regwrite_en, spc_we, muldiv_start, active;
  logic [2:0] state_o;

  sb_entry_t sb_q[$];
  int        tests_run = 0;
  int        failures  = 0;

  mips_cpu_seq_ctrl #(
    .MULDIV_LAT (32),
    .MULT_LAT   (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .waitrequest  (waitrequest),
    .dec_load     (dec_load),
    .dec_store    (dec_store),
    .dec_muldiv   (dec_muldiv),
    .dec_mult     (dec_mult),
    .dec_regwrite (dec_regwrite),
    .branch_taken (branch_taken),
    .next_pc_zero (next_pc_zero),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr_sel     (addr_sel),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .regwrite_en  (regwrite_en),
    .spc_we       (spc_we),
    .muldiv_start (muldiv_start),
    .active       (active),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ev(input logic [2:0] st, input logic [9:0] f);
    return {st, f};
  endfunction

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t   e;
      logic [12:0] got;
      e   = sb_q.pop_front();
      got = {state_o, mem_read, mem_write, addr_sel, ir_en, pc_en, pc_sel,
             regwrite_en, spc_we, muldiv_start, active};
      tests_run++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got st=%0d flags=%b, expected st=%0d flags=%b",
                 e.name, got[12:10], got[9:0], e.exp[12:10], e.exp[9:0]);
      end
    end
  end

  task automatic step(input logic [12:0] exp, input string nm);
    sb_q.push_back('{exp, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic l, input logic s, input logic md, input logic mu,
                         input logic rw, input logic bt, input logic npz);
    dec_load = l; dec_store = s; dec_muldiv = md; dec_mult = mu;
    dec_regwrite = rw; branch_taken = bt; next_pc_zero = npz;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      waitrequest = 1'b1;
      step(ev(3'd0, MR | ACT), "fetch_wait");
    end
    waitrequest = 1'b0;
    step(ev(3'd0, MR | IR | ACT), "fetch");
  endtask

  task automatic alu(input logic rw, input logic bt, input logic exp_ps, input string nm);
    set_dec(0, 0, 0, 0, rw, bt, 0);
    fetch(0);
    step(ev(3'd1, PE | (rw ? RW : 10'h0) | (exp_ps ? PS : 10'h0) | ACT), nm);
  endtask

  task automatic muldiv(input logic mu, input int lat, input string nm);
    set_dec(0, 0, 1, mu, 0, 0, 0);
    fetch(0);
    step(ev(3'd1, MS | ACT), "muldiv_exec");
    for (int i = 0; i < lat - 1; i++) step(ev(3'd3, ACT), "muldiv_wait");
    step(ev(3'd3, SPC | PE | ACT), nm);
  endtask

  initial begin
    // Reset asserted with a stalled fetch: FETCH bus command only.
    @(posedge clk); #1;
    step(ev(3'd0, MR | ACT), "reset_state");
    reset_n = 1'b1;

    alu(1, 0, 0, "alu_commit");

    // Load stalled for three MEM cycles.
    set_dec(1, 0, 0, 0, 1, 0, 0);
    fetch(1);
    step(ev(3'd1, ACT), "load_exec");
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) step(ev(3'd2, MR | AS | ACT), "load_mem_wait");
    waitrequest = 1'b0;
    step(ev(3'd2, MR | AS | RW | PE | ACT), "load_commit");

    // Store, no stall; decoder regwrite must not leak through.
    set_dec(0, 1, 0, 0, 1, 0, 0);
    fetch(0);
    step(ev(3'd1, ACT), "store_exec");
    step(ev(3'd2, MW | AS | PE | ACT), "store_commit");

    muldiv(0, 32, "div_commit");
    muldiv(1, MULT_EXP, "mult_commit");

    // Taken branch, delay slot, then a normal instruction.
    alu(0, 1, 0, "branch_commit");
    alu(1, 0, 1, "delay_slot_commit");
    alu(1, 0, 0, "after_slot_commit");

    // Branch in the delay slot must not re-arm the pending target.
    alu(0, 1, 0, "branch2_commit");
    alu(0, 1, 1, "slot_branch_commit");
    alu(1, 0, 0, "after_slot_branch");

    // Delay slot holding a load uses the target on its MEM commit.
    alu(0, 1, 0, "branch3_commit");
    set_dec(1, 0, 0, 0, 1, 0, 0);
    fetch(0);
    step(ev(3'd1, ACT), "slot_load_exec");
    step(ev(3'd2, MR | AS | RW | PE | PS | ACT), "slot_load_commit");

    // Reset during a stalled MEM cycle aborts the bus command at once.
    set_dec(1, 0, 0, 0, 1, 0, 0);
    fetch(0);
    step(ev(3'd1, ACT), "abort_exec");
    waitrequest = 1'b1;
    step(ev(3'd2, MR | AS | ACT), "abort_mem_wait");
    reset_n = 1'b0;
    step(ev(3'd0, MR | ACT), "abort_reset");
    reset_n = 1'b1;

    // Jump to zero halts.
    set_dec(0, 0, 0, 0, 1, 1, 1);
    fetch(0);
    step(ev(3'd1, PE | RW | ACT), "halt_commit");
    for (int i = 0; i < 100; i++) begin
      waitrequest = i[0];
      set_dec(i[1], i[2], i[3], i[4], 1, 1, i[5]);
      step(ev(3'd4, 10'h0), "halted");
    end
    reset_n = 1'b0;
    waitrequest = 1'b0;
    step(ev(3'd0, MR | IR | ACT), "halt_async_reset");
    reset_n = 1'b1;

    alu(1, 0, 0, "post_halt_alu");

    @(negedge clk); #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
